// File: rtl/clkgen_rst_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : clkgen_rst_seq_if
// Brief    : Lock/request inputs and sequenced reset outputs of clkgen_rst_seq.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface clkgen_rst_seq_if #(
    parameter int NUM_RST = 3
);
    logic               pll_locked_i;
    logic               soft_rst_req_i;
    logic [NUM_RST-1:0] rst_n_o;
    logic               seq_done_o;
    logic [1:0]         state_o;
    logic [7:0]         lock_loss_cnt_o;

    modport master (
        input  pll_locked_i,
        input  soft_rst_req_i,
        output rst_n_o,
        output seq_done_o,
        output state_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output pll_locked_i,
        output soft_rst_req_i,
        input  rst_n_o,
        input  seq_done_o,
        input  state_o,
        input  lock_loss_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/clkgen_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : clkgen_rst_seq
// Brief    : Synchronises reset and PLL lock, debounces lock, then releases
//            NUM_RST reset domains in order; re-asserts on lock loss/soft request.
// Revision : 1.0
// ----------------------------------------------------------------------------
module clkgen_rst_seq #(
    parameter int NUM_RST            = 3,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP        = 16,
    parameter int MIN_ASSERT_CYCLES  = 8
) (
    input  wire              IO_CLK,
    input  wire              IO_RST_N,
    clkgen_rst_seq_if.master rst_if
);

    localparam int c_MAX_A   = (MIN_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ? MIN_ASSERT_CYCLES
                                                                        : LOCK_STABLE_CYCLES;
    localparam int c_MAX_CNT = (c_MAX_A > RELEASE_GAP) ? c_MAX_A : RELEASE_GAP;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam int c_IDX_W   = $clog2(NUM_RST) + 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(RELEASE_GAP - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_RST - 1);

    localparam logic [1:0] c_HOLD      = 2'd0;
    localparam logic [1:0] c_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_RELEASE   = 2'd2;
    localparam logic [1:0] c_RUN       = 2'd3;

    if (NUM_RST < 1 || NUM_RST > 8) begin : g_chk_num_rst
        $error("clkgen_rst_seq: NUM_RST must be in 1..8");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync_stages
        $error("clkgen_rst_seq: SYNC_STAGES must be >= 2");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_chk_lock_stable
        $error("clkgen_rst_seq: LOCK_STABLE_CYCLES must be >= 1");
    end
    if (RELEASE_GAP < 1) begin : g_chk_release_gap
        $error("clkgen_rst_seq: RELEASE_GAP must be >= 1");
    end
    if (MIN_ASSERT_CYCLES < 1) begin : g_chk_min_assert
        $error("clkgen_rst_seq: MIN_ASSERT_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_RST-1:0]     r_rst_n;
    logic                   r_done;
    logic [7:0]             r_llc;

    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [NUM_RST-1:0]     w_rst_n_nxt;
    logic                   w_done_nxt;
    logic [7:0]             w_llc_nxt;

    logic                   w_rst_ok;
    logic                   w_lock_s;
    logic                   w_soft;
    logic                   w_abort;
    logic                   w_lock_done;
    logic                   w_gap_done;
    logic [c_IDX_W-1:0]     w_idx_rel;
    logic                   w_last;
    logic [NUM_RST-1:0]     w_rel_vec;

    // Both synchronisers clear asynchronously and fill with a 1 / the lock level.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_rst_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], rst_if.pll_locked_i};
        end
    end

    assign w_rst_ok    = r_rst_sync[SYNC_STAGES-1];
    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_soft      = rst_if.soft_rst_req_i;
    assign w_abort     = !w_lock_s || w_soft;
    assign w_lock_done = (r_state == c_WAIT_LOCK) && !w_soft && w_lock_s && (r_cnt == c_LOCK_LAST);
    assign w_gap_done  = (r_state == c_RELEASE) && !w_abort && (r_cnt == c_GAP_LAST);
    assign w_idx_rel   = w_lock_done ? '0 : r_idx + 1'b1;
    assign w_last      = (w_idx_rel == c_LAST_IDX);
    // Released bits form a thermometer code, so one more release is a shift-in of 1.
    assign w_rel_vec   = (r_rst_n << 1) | NUM_RST'(1);

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_state <= c_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_llc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_done  <= w_done_nxt;
            r_llc   <= w_llc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (w_rst_ok) begin
            case (r_state)
                c_HOLD: begin
                    if (w_soft) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt = c_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_WAIT_LOCK: begin
                    if (w_soft) begin
                        w_state_nxt = c_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (!w_lock_s) begin
                        w_cnt_nxt = '0;
                    end else if (w_lock_done) begin
                        w_state_nxt = w_last ? c_RUN : c_RELEASE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = w_idx_rel;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_RELEASE: begin
                    if (w_abort) begin
                        w_state_nxt = c_HOLD;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else if (w_gap_done) begin
                        w_state_nxt = w_last ? c_RUN : c_RELEASE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = w_idx_rel;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_abort) begin
                        w_state_nxt = c_HOLD;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
            endcase
        end
    end

    // Next values of the registered outputs; the abort path clears all domains at once.
    always_comb begin
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = r_done;
        w_llc_nxt   = r_llc;
        if (w_rst_ok) begin
            case (r_state)
                c_HOLD: begin
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
                c_WAIT_LOCK: begin
                    if (w_lock_done) begin
                        w_rst_n_nxt = w_rel_vec;
                        w_done_nxt  = w_last;
                    end
                end
                default: begin
                    if (w_abort) begin
                        w_rst_n_nxt = '0;
                        w_done_nxt  = 1'b0;
                        if (!w_lock_s && (r_llc != 8'hFF)) begin
                            w_llc_nxt = r_llc + 8'd1;
                        end
                    end else if (w_gap_done) begin
                        w_rst_n_nxt = w_rel_vec;
                        w_done_nxt  = w_last;
                    end
                end
            endcase
        end
    end

    assign rst_if.rst_n_o         = r_rst_n;
    assign rst_if.seq_done_o      = r_done;
    assign rst_if.state_o         = r_state;
    assign rst_if.lock_loss_cnt_o = r_llc;

endmodule
`default_nettype wire

// File: tb/tb_clkgen_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_clkgen_rst_seq
// Brief    : Directed self-checking bench for clkgen_rst_seq (3 domains, short timers).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_clkgen_rst_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected outputs on the k-th edge (k=1..11) after HOLD starts counting.
    localparam logic [1:0] SEQ_ST [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                           2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    localparam logic [2:0] SEQ_RN [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                           3'b001, 3'b001, 3'b011, 3'b011, 3'b111};

    clkgen_rst_seq_if #(.NUM_RST(3)) bus ();

    clkgen_rst_seq #(
        .NUM_RST            (3),
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (4),
        .RELEASE_GAP        (2),
        .MIN_ASSERT_CYCLES  (3)
    ) dut (
        .IO_CLK   (clk),
        .IO_RST_N (rst_n),
        .rst_if   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic [2:0] rn,
                           input logic dn);
        chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
        chk({tag, "_rst_n"}, 32'(bus.rst_n_o), 32'(rn));
        chk({tag, "_done"},  32'(bus.seq_done_o), 32'(dn));
    endtask

    // Call right after the edge on which HOLD starts with cnt=0 and lock is stable.
    task automatic run_seq(input string tag);
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            chk_out($sformatf("%s_k%0d", tag, k), SEQ_ST[k-1], SEQ_RN[k-1], k == 11);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int max_cyc, input string tag);
        int c;
        c = 0;
        while (bus.state_o != st && c < max_cyc) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(bus.state_o), 32'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.pll_locked_i   = 1'b1;
        bus.soft_rst_req_i = 1'b0;
        rst_n              = 1'b0;
        tick(3);
        chk_out("reset", 2'd0, 3'b000, 1'b0);
        chk("reset_llc", 32'(bus.lock_loss_cnt_o), 32'd0);

        // 1: lock high from reset release
        rst_n = 1'b1;
        tick(1);
        chk_out("t1_sync1", 2'd0, 3'b000, 1'b0);
        tick(1);
        chk_out("t1_sync2", 2'd0, 3'b000, 1'b0);
        run_seq("t1");

        // 2: one-cycle lock glitch while WAIT_LOCK cnt=2
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("t2_wait", 32'(bus.state_o), 32'd1);
        bus.pll_locked_i = 1'b0;
        tick(1);
        bus.pll_locked_i = 1'b1;
        tick(3);
        chk_out("t2_e9", 2'd1, 3'b000, 1'b0);
        tick(2);
        chk_out("t2_e11", 2'd1, 3'b000, 1'b0);
        tick(1);
        chk_out("t2_e12", 2'd2, 3'b001, 1'b0);
        tick(2);
        chk_out("t2_e14", 2'd2, 3'b011, 1'b0);
        tick(2);
        chk_out("t2_e16", 2'd3, 3'b111, 1'b1);

        // 3: lock drop in RUN
        bus.pll_locked_i = 1'b0;
        tick(2);
        chk_out("t3_run", 2'd3, 3'b111, 1'b1);
        tick(1);
        chk_out("t3_abort", 2'd0, 3'b000, 1'b0);
        chk("t3_llc", 32'(bus.lock_loss_cnt_o), 32'd1);
        bus.pll_locked_i = 1'b1;
        run_seq("t3");

        // 4: soft requests in RUN, RELEASE and HOLD
        bus.soft_rst_req_i = 1'b1;
        tick(1);
        bus.soft_rst_req_i = 1'b0;
        chk_out("t4_run_abort", 2'd0, 3'b000, 1'b0);
        tick(9);
        chk_out("t4_rel", 2'd2, 3'b011, 1'b0);
        bus.soft_rst_req_i = 1'b1;
        tick(1);
        bus.soft_rst_req_i = 1'b0;
        chk_out("t4_rel_abort", 2'd0, 3'b000, 1'b0);
        chk("t4_llc", 32'(bus.lock_loss_cnt_o), 32'd1);
        tick(1);
        bus.soft_rst_req_i = 1'b1;
        tick(1);
        bus.soft_rst_req_i = 1'b0;
        chk("t4_hold0", 32'(bus.state_o), 32'd0);
        tick(1);
        chk("t4_hold1", 32'(bus.state_o), 32'd0);
        tick(1);
        chk("t4_hold2", 32'(bus.state_o), 32'd0);
        tick(1);
        chk("t4_wait", 32'(bus.state_o), 32'd1);

        // 5: async reset between edges mid-RELEASE
        tick(4);
        chk_out("t5_rel", 2'd2, 3'b001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5_async", 2'd0, 3'b000, 1'b0);
        chk("t5_llc", 32'(bus.lock_loss_cnt_o), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk_out("t5_sync1", 2'd0, 3'b000, 1'b0);
        tick(1);
        chk_out("t5_sync2", 2'd0, 3'b000, 1'b0);
        run_seq("t5");

        // 6a: lock loss and soft request on the same cycle count once
        bus.pll_locked_i = 1'b0;
        tick(2);
        bus.soft_rst_req_i = 1'b1;
        tick(1);
        bus.soft_rst_req_i = 1'b0;
        bus.pll_locked_i   = 1'b1;
        chk_out("t6_both", 2'd0, 3'b000, 1'b0);
        chk("t6_both_llc", 32'(bus.lock_loss_cnt_o), 32'd1);

        // 6b: 300 lock losses during RELEASE, counter saturates
        for (int i = 1; i <= 300; i++) begin
            wait_state(2'd2, 40, "t6_wait_rel");
            bus.pll_locked_i = 1'b0;
            tick(3);
            bus.pll_locked_i = 1'b1;
            if (i == 1)   chk("t6_abort_state", 32'(bus.state_o), 32'd0);
            if (i == 253) chk("t6_llc_254", 32'(bus.lock_loss_cnt_o), 32'd254);
            if (i == 254) chk("t6_llc_255", 32'(bus.lock_loss_cnt_o), 32'd255);
            if (i == 255) chk("t6_llc_sat", 32'(bus.lock_loss_cnt_o), 32'd255);
            if (i == 300) chk("t6_llc_end", 32'(bus.lock_loss_cnt_o), 32'd255);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
